alu_station: RTL and testbench

- Reservation station directly upstream of the integer ALU in the out-of-order RISC-V core.
- Buffers issued ALU/branch/jump instructions until both source operands are available, snooping the common data bus (CDB) for them.
- Dispatches one ready entry per cycle to the combinational ALU and registers the ALU result onto its own CDB output port, tagged with the ROB destination.

---
 rtl/alu_station_pkg.sv | 61 ++++++
 rtl/alu_station_if.sv | 60 ++++++
 rtl/alu_station_rs_select.sv | 23 ++
 rtl/alu_station.sv | 120 ++++++++++++
 tb/tb_alu_station.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_station_pkg.sv
// Shared types for the integer ALU reservation station: tags, operands, entries,
// CDB payloads and the operand wakeup helper.
package alu_station_pkg;

    localparam int unsigned RS_SIZE      = 8;
    localparam int unsigned TAG_WIDTH    = 4;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned RS_IDX_WIDTH = $clog2(RS_SIZE);

    typedef logic [TAG_WIDTH-1:0]    tag_t;
    typedef logic [RS_IDX_WIDTH-1:0] rs_idx_t;
    typedef logic [XLEN-1:0]         word_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_BEQ  = 4'd4,
        OP_JAL  = 4'd5
    } op_t;

    typedef struct packed {
        logic  pend;
        tag_t  tag;
        word_t val;
    } operand_t;

    typedef struct packed {
        logic     busy;
        op_t      op;
        operand_t j;
        operand_t k;
        word_t    pc;
        word_t    imm;
        tag_t     dest;
    } rs_entry_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        word_t value;
    } cdb_t;

    // Resolve a pending operand from either broadcast; our own CDB wins a tie.
    function automatic operand_t wake(operand_t o, cdb_t own, cdb_t ext);
        operand_t r;
        r = o;
        if (o.pend) begin
            if (own.valid && own.tag == o.tag) begin
                r.pend = 1'b0;
                r.val  = own.value;
            end else if (ext.valid && ext.tag == o.tag) begin
                r.pend = 1'b0;
                r.val  = ext.value;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_station_if.sv
// Issue, CDB-in, ALU and CDB-out signal bundle of the ALU reservation station.
interface alu_station_if;
    import alu_station_pkg::*;

    logic  rdy;
    logic  flush;

    logic  issue_valid;
    op_t   issue_op;
    word_t issue_vj;
    tag_t  issue_qj;
    logic  issue_qj_pend;
    word_t issue_vk;
    tag_t  issue_qk;
    logic  issue_qk_pend;
    word_t issue_pc;
    word_t issue_imm;
    tag_t  issue_dest;
    logic  full;

    logic  cdb_in_valid;
    tag_t  cdb_in_tag;
    word_t cdb_in_value;

    op_t   alu_op;
    word_t alu_rs;
    word_t alu_rt;
    word_t alu_pc;
    word_t alu_imm;
    word_t alu_value;
    word_t alu_next_pc;

    logic  cdb_out_valid;
    tag_t  cdb_out_tag;
    word_t cdb_out_value;
    word_t cdb_out_next_pc;

    modport slave (
        input  rdy, flush,
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_qj_pend,
        input  issue_vk, issue_qk, issue_qk_pend, issue_pc, issue_imm, issue_dest,
        output full,
        input  cdb_in_valid, cdb_in_tag, cdb_in_value,
        output alu_op, alu_rs, alu_rt, alu_pc, alu_imm,
        input  alu_value, alu_next_pc,
        output cdb_out_valid, cdb_out_tag, cdb_out_value, cdb_out_next_pc
    );

    modport master (
        output rdy, flush,
        output issue_valid, issue_op, issue_vj, issue_qj, issue_qj_pend,
        output issue_vk, issue_qk, issue_qk_pend, issue_pc, issue_imm, issue_dest,
        input  full,
        output cdb_in_valid, cdb_in_tag, cdb_in_value,
        input  alu_op, alu_rs, alu_rt, alu_pc, alu_imm,
        output alu_value, alu_next_pc,
        input  cdb_out_valid, cdb_out_tag, cdb_out_value, cdb_out_next_pc
    );

endinterface

// File: rtl/alu_station_rs_select.sv
// Lowest-index priority encoder: request vector to index plus found flag.
module alu_station_rs_select #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan high to low so the lowest requesting index is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_station.sv
// Reservation station in front of the integer ALU: buffers issued ops, snoops the
// CDBs for operands, dispatches one ready entry per cycle, registers the result.
module alu_station
    import alu_station_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_station_if.slave  bus
);

    rs_entry_t            entries     [RS_SIZE];
    rs_entry_t            entries_nxt [RS_SIZE];
    logic [RS_SIZE-1:0]   free_req;
    logic [RS_SIZE-1:0]   ready_req;
    rs_idx_t              free_idx;
    rs_idx_t              sel_idx;
    logic                 free_found;
    logic                 sel_found;
    cdb_t                 cdb_q;
    cdb_t                 cdb_nxt;
    cdb_t                 ext;
    word_t                next_pc_q;
    word_t                next_pc_nxt;
    operand_t             iss_j;
    operand_t             iss_k;

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            free_req[i]  = !entries[i].busy;
            ready_req[i] = entries[i].busy && !entries[i].j.pend && !entries[i].k.pend;
        end
    end

    alu_station_rs_select #(.N(RS_SIZE), .IW(RS_IDX_WIDTH)) u_free_sel (
        .req   (free_req),
        .idx   (free_idx),
        .found (free_found)
    );

    alu_station_rs_select #(.N(RS_SIZE), .IW(RS_IDX_WIDTH)) u_ready_sel (
        .req   (ready_req),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign bus.full = !free_found;
    assign ext      = '{valid: bus.cdb_in_valid, tag: bus.cdb_in_tag, value: bus.cdb_in_value};

    // Selected entry drives the external ALU; zeros when idle.
    always_comb begin
        bus.alu_op  = OP_NOP;
        bus.alu_rs  = '0;
        bus.alu_rt  = '0;
        bus.alu_pc  = '0;
        bus.alu_imm = '0;
        if (sel_found) begin
            bus.alu_op  = entries[sel_idx].op;
            bus.alu_rs  = entries[sel_idx].j.val;
            bus.alu_rt  = entries[sel_idx].k.val;
            bus.alu_pc  = entries[sel_idx].pc;
            bus.alu_imm = entries[sel_idx].imm;
        end
    end

    // Next-state: wakeup, completion and issue; flush drops all of it.
    always_comb begin
        entries_nxt = entries;
        cdb_nxt       = cdb_q;
        cdb_nxt.valid = 1'b0;
        next_pc_nxt   = next_pc_q;
        iss_j = '{pend: bus.issue_qj_pend, tag: bus.issue_qj, val: bus.issue_vj};
        iss_k = '{pend: bus.issue_qk_pend, tag: bus.issue_qk, val: bus.issue_vk};
        if (bus.flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries_nxt[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (entries[i].busy) begin
                    entries_nxt[i].j = wake(entries[i].j, cdb_q, ext);
                    entries_nxt[i].k = wake(entries[i].k, cdb_q, ext);
                end
            end
            if (sel_found) begin
                entries_nxt[sel_idx].busy = 1'b0;
                cdb_nxt     = '{valid: 1'b1, tag: entries[sel_idx].dest, value: bus.alu_value};
                next_pc_nxt = bus.alu_next_pc;
            end
            if (bus.issue_valid && free_found) begin
                entries_nxt[free_idx].busy = 1'b1;
                entries_nxt[free_idx].op   = bus.issue_op;
                entries_nxt[free_idx].j    = wake(iss_j, cdb_q, ext);
                entries_nxt[free_idx].k    = wake(iss_k, cdb_q, ext);
                entries_nxt[free_idx].pc   = bus.issue_pc;
                entries_nxt[free_idx].imm  = bus.issue_imm;
                entries_nxt[free_idx].dest = bus.issue_dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries[i] <= '0;
            end
            cdb_q     <= '0;
            next_pc_q <= '0;
        end else if (bus.rdy) begin
            entries   <= entries_nxt;
            cdb_q     <= cdb_nxt;
            next_pc_q <= next_pc_nxt;
        end
    end

    assign bus.cdb_out_valid   = cdb_q.valid;
    assign bus.cdb_out_tag     = cdb_q.tag;
    assign bus.cdb_out_value   = cdb_q.value;
    assign bus.cdb_out_next_pc = next_pc_q;

endmodule

// File: tb/tb_alu_station.sv
// Scoreboard bench for alu_station: directed issues push expected broadcasts,
// a negedge monitor pops and compares tag, value, next_pc and arrival edge.
module tb_alu_station;
    import alu_station_pkg::*;

    typedef struct {
        tag_t  tag;
        word_t value;
        word_t npc;
        int    at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic active_q = 1'b0;
    exp_t sb[$];

    alu_station_if bus ();

    alu_station dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the parent's combinational ALU.
    always_comb begin
        bus.alu_value   = '0;
        bus.alu_next_pc = '0;
        case (bus.alu_op)
            OP_ADD:  bus.alu_value = bus.alu_rs + bus.alu_rt;
            OP_SUB:  bus.alu_value = bus.alu_rs - bus.alu_rt;
            OP_ADDI: bus.alu_value = bus.alu_rs + bus.alu_imm;
            OP_BEQ:  bus.alu_next_pc = (bus.alu_rs == bus.alu_rt) ? bus.alu_pc + bus.alu_imm
                                                                  : bus.alu_pc + 32'd4;
            OP_JAL: begin
                bus.alu_value   = bus.alu_pc + 32'd4;
                bus.alu_next_pc = bus.alu_pc + bus.alu_imm;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        active_q <= rst && bus.rdy;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Only broadcasts produced by an active edge are consumed, so held outputs are not re-popped.
    always @(negedge clk) begin
        exp_t e;
        if (active_q && bus.cdb_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bcast: got tag %0h value %0h expected no broadcast (cycle %0d)",
                         bus.cdb_out_tag, bus.cdb_out_value, cyc);
            end else begin
                e = sb.pop_front();
                chk("cdb_tag",     32'(bus.cdb_out_tag), 32'(e.tag));
                chk("cdb_value",   bus.cdb_out_value,    e.value);
                chk("cdb_next_pc", bus.cdb_out_next_pc,  e.npc);
                chk("cdb_edge",    32'(cyc),             32'(e.at));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(tag_t tag, word_t value, word_t npc, int at);
        exp_t e;
        e.tag = tag; e.value = value; e.npc = npc; e.at = at;
        sb.push_back(e);
    endtask

    task automatic drive_issue(op_t op, word_t vj, tag_t qj, logic qjp, word_t vk, tag_t qk,
                               logic qkp, word_t pc, word_t imm, tag_t dest);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_qj      = qj;
        bus.issue_qj_pend = qjp;
        bus.issue_vk      = vk;
        bus.issue_qk      = qk;
        bus.issue_qk_pend = qkp;
        bus.issue_pc      = pc;
        bus.issue_imm     = imm;
        bus.issue_dest    = dest;
    endtask

    task automatic idle_issue();
        bus.issue_valid = 1'b0;
    endtask

    task automatic drive_cdb(logic v, tag_t t, word_t val);
        bus.cdb_in_valid = v;
        bus.cdb_in_tag   = t;
        bus.cdb_in_value = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.rdy   = 1'b1;
        bus.flush = 1'b0;
        drive_issue(OP_NOP, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        idle_issue();
        drive_cdb(1'b0, '0, '0);
        tick();
        tick();

        chk("rst_full",        32'(bus.full),          32'd0);
        chk("rst_cdb_valid",   32'(bus.cdb_out_valid), 32'd0);
        chk("rst_cdb_tag",     32'(bus.cdb_out_tag),   32'd0);
        chk("rst_cdb_value",   bus.cdb_out_value,      32'd0);
        chk("rst_cdb_next_pc", bus.cdb_out_next_pc,    32'd0);
        chk("rst_alu_op",      32'(bus.alu_op),        32'(OP_NOP));
        chk("rst_alu_rs",      bus.alu_rs,             32'd0);
        rst = 1'b1;

        // ADDI 5+7 -> tag 3, broadcast two edges after presentation
        drive_issue(OP_ADDI, 32'd5, '0, 1'b0, '0, '0, 1'b0, '0, 32'd7, 4'd3);
        push(4'd3, 32'd12, 32'd0, cyc + 2);
        chk("t1_full_pre", 32'(bus.full), 32'd0);
        tick();
        idle_issue();
        chk("t1_full",    32'(bus.full),   32'd0);
        chk("t1_alu_op",  32'(bus.alu_op), 32'(OP_ADDI));
        chk("t1_alu_rs",  bus.alu_rs,      32'd5);
        chk("t1_alu_imm", bus.alu_imm,     32'd7);
        tick();
        chk("t1_full_post", 32'(bus.full), 32'd0);
        tick();

        // ADD waiting on tag 2, woken by external CDB
        drive_issue(OP_ADD, '0, 4'd2, 1'b1, 32'd10, '0, 1'b0, '0, '0, 4'd4);
        tick();
        idle_issue();
        chk("t2_not_ready", 32'(bus.alu_op), 32'(OP_NOP));
        tick();
        tick();
        drive_cdb(1'b1, 4'd2, 32'd20);
        push(4'd4, 32'd30, 32'd0, cyc + 2);
        tick();
        drive_cdb(1'b0, '0, '0);
        chk("t2_alu_rs", bus.alu_rs, 32'd20);
        chk("t2_alu_rt", bus.alu_rt, 32'd10);
        tick();
        tick();

        // SUB whose rs arrives on the CDB in its issue cycle: 9-4
        drive_issue(OP_SUB, '0, 4'd6, 1'b1, 32'd4, '0, 1'b0, '0, '0, 4'd5);
        drive_cdb(1'b1, 4'd6, 32'd9);
        push(4'd5, 32'd5, 32'd0, cyc + 2);
        tick();
        idle_issue();
        drive_cdb(1'b0, '0, '0);
        chk("t3_fwd_rs", bus.alu_rs, 32'd9);
        tick();
        tick();

        // Chain: A (dest 1) feeds B through our own CDB; a conflicting external tag 1 loses
        drive_issue(OP_ADDI, 32'd100, '0, 1'b0, '0, '0, 1'b0, '0, 32'd1, 4'd1);
        push(4'd1, 32'd101, 32'd0, cyc + 2);
        tick();
        drive_issue(OP_ADD, '0, 4'd1, 1'b1, 32'd50, '0, 1'b0, '0, '0, 4'd2);
        push(4'd2, 32'd151, 32'd0, cyc + 3);
        tick();
        idle_issue();
        drive_cdb(1'b1, 4'd1, 32'd999);
        tick();
        drive_cdb(1'b0, '0, '0);
        tick();
        tick();

        // Branch taken and JAL with tag 0
        drive_issue(OP_BEQ, 32'd7, '0, 1'b0, 32'd7, '0, 1'b0, 32'h100, 32'h20, 4'd7);
        push(4'd7, 32'd0, 32'h120, cyc + 2);
        tick();
        drive_issue(OP_JAL, '0, '0, 1'b0, '0, '0, 1'b0, 32'h200, 32'h40, 4'd0);
        push(4'd0, 32'h204, 32'h240, cyc + 2);
        tick();
        idle_issue();
        tick();
        tick();

        // Fill all slots with pending ops, drop a ninth, then flush with a discarded issue and wakeup
        for (int i = 0; i < 8; i++) begin
            drive_issue(OP_ADD, '0, 4'd9, 1'b1, 32'd1, '0, 1'b0, '0, '0, tag_t'(8 + i));
            chk("t5_fill_full", 32'(bus.full), 32'd0);
            tick();
        end
        idle_issue();
        chk("t5_full", 32'(bus.full), 32'd1);
        drive_issue(OP_ADDI, 32'd1, '0, 1'b0, '0, '0, 1'b0, '0, 32'd1, 4'd15);
        tick();
        idle_issue();
        chk("t5_full_after_drop", 32'(bus.full), 32'd1);
        bus.flush = 1'b1;
        drive_cdb(1'b1, 4'd9, 32'd77);
        drive_issue(OP_ADDI, 32'd1, '0, 1'b0, '0, '0, 1'b0, '0, 32'd1, 4'd14);
        tick();
        bus.flush = 1'b0;
        idle_issue();
        chk("t5_flush_full",  32'(bus.full),          32'd0);
        chk("t5_flush_valid", 32'(bus.cdb_out_valid), 32'd0);
        chk("t5_flush_alu",   32'(bus.alu_op),        32'(OP_NOP));
        tick();
        drive_cdb(1'b0, '0, '0);
        tick();
        tick();

        // rdy=0 for three cycles while a broadcast is on the bus
        drive_issue(OP_ADDI, 32'd3, '0, 1'b0, '0, '0, 1'b0, '0, 32'd4, 4'd6);
        push(4'd6, 32'd7, 32'd0, cyc + 2);
        tick();
        drive_issue(OP_ADD, '0, 4'd13, 1'b1, 32'd0, '0, 1'b0, '0, '0, 4'd12);
        tick();
        bus.rdy = 1'b0;
        drive_cdb(1'b1, 4'd13, 32'd40);
        drive_issue(OP_ADDI, 32'd5, '0, 1'b0, '0, '0, 1'b0, '0, 32'd5, 4'd13);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_valid", 32'(bus.cdb_out_valid), 32'd1);
            chk("t6_hold_tag",   32'(bus.cdb_out_tag),   32'd6);
            chk("t6_hold_value", bus.cdb_out_value,      32'd7);
            chk("t6_hold_alu",   32'(bus.alu_op),        32'(OP_NOP));
        end
        bus.rdy = 1'b1;
        idle_issue();
        drive_cdb(1'b0, '0, '0);
        tick();
        chk("t6_resume_valid", 32'(bus.cdb_out_valid), 32'd0);
        drive_cdb(1'b1, 4'd13, 32'd40);
        push(4'd12, 32'd40, 32'd0, cyc + 2);
        tick();
        drive_cdb(1'b0, '0, '0);
        tick();
        tick();

        // Reset while an entry is pending and a broadcast is live
        drive_issue(OP_ADD, '0, 4'd14, 1'b1, 32'd2, '0, 1'b0, '0, '0, 4'd11);
        tick();
        drive_issue(OP_ADDI, 32'd1, '0, 1'b0, '0, '0, 1'b0, '0, 32'd1, 4'd10);
        push(4'd10, 32'd2, 32'd0, cyc + 2);
        tick();
        idle_issue();
        tick();
        rst = 1'b0;
        tick();
        chk("t7_rst_valid",   32'(bus.cdb_out_valid), 32'd0);
        chk("t7_rst_tag",     32'(bus.cdb_out_tag),   32'd0);
        chk("t7_rst_value",   bus.cdb_out_value,      32'd0);
        chk("t7_rst_next_pc", bus.cdb_out_next_pc,    32'd0);
        chk("t7_rst_full",    32'(bus.full),          32'd0);
        chk("t7_rst_alu",     32'(bus.alu_op),        32'(OP_NOP));
        rst = 1'b1;
        drive_cdb(1'b1, 4'd14, 32'd5);
        tick();
        drive_cdb(1'b0, '0, '0);
        tick();
        tick();

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            tick();
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
